// File: rtl/sprite_linebuf_scanout.sv
// sprite_linebuf_scanout
//   Consumer end of the sprite engine's pixel-write interface. Two WIDTH x 16
//   line buffers work in ping-pong. The engine fills bank wsel with the next
//   line while bank ~wsel is scanned out to the compositor. Each scanned
//   location is cleared back to the transparent key one cycle after it is read.
//   At hcount == 799 the banks swap, sprite_start pulses on the following
//   cycle, and a line the engine had not finished is counted in overrun_cnt.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   pix_ce             pixel clock enable (one cycle in two)
//   hcount, vcount     current raster position (0..799, 0..524)
//   sprite_pixel_col   engine write column
//   sprite_pixel_data  engine write data (RGB565)
//   wren_pixel_draw    engine write strobe
//   sprite_done        engine finished the current line (level)
//   sprite_start       one-cycle pulse: render the next line
//   pixel_data         RGB565 sprite pixel, two clk after its pix_ce edge
//   pixel_valid        pixel_data is opaque and on the visible raster
//   init_done          initial buffer clear complete
//   overrun_cnt        saturating count of lines the engine finished late
module sprite_linebuf_scanout #(
    parameter int          WIDTH       = 640,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  sprite_pixel_col,
    input  logic [15:0] sprite_pixel_data,
    input  logic        wren_pixel_draw,
    input  logic        sprite_done,
    output logic        sprite_start,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        init_done,
    output logic [7:0]  overrun_cnt
);

    localparam logic [0:0] ST_INIT   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [9:0] WIDTH_L   = 10'(WIDTH);
    localparam logic [9:0] LAST_COL  = 10'(WIDTH - 1);
    localparam logic [9:0] H_SWAP    = 10'd799;
    localparam logic [9:0] V_VISIBLE = 10'd480;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [9:0]  clr_addr_q, clr_addr_d;
    logic        wsel_q, wsel_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        start_q, start_d;

    logic [15:0] bank0 [WIDTH];
    logic [15:0] bank1 [WIDTH];

    logic        b0_we, b1_we;
    logic [9:0]  b0_addr, b1_addr;
    logic [15:0] b0_wdata, b1_wdata;

    logic        run, swap, rd_en, eng_we, clr_ok;

    logic        vld_p1, clr_p1, rd_bank_p1;
    logic [9:0]  rd_addr_p1, hcount_p1, vcount_p1;
    logic [15:0] rd_data_p1;

    logic [15:0] pix_data_p2;
    logic        pix_valid_p2;

    assign run    = (state_q == ST_RUN);
    assign swap   = run && pix_ce && (hcount == H_SWAP);
    assign rd_en  = run && pix_ce && (hcount < WIDTH_L);
    assign eng_we = run && wren_pixel_draw && (sprite_pixel_col < WIDTH_L)
                    && (sprite_pixel_data != TRANSPARENT);
    assign clr_ok = (clr_addr_q < WIDTH_L);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wsel_d     = wsel_q;
        ovr_d      = ovr_q;
        start_d    = 1'b0;
        if (!run) begin
            if (clr_addr_q == LAST_COL) begin
                state_d = ST_RUN;
            end else begin
                clr_addr_d = clr_addr_q + 10'd1;
            end
        end else if (swap) begin
            wsel_d  = ~wsel_q;
            start_d = 1'b1;
            if (!sprite_done) begin
                ovr_d = sat_inc8(ovr_q);
            end
        end
    end

    // One write port per bank. During INIT both banks take the clear address.
    // In RUN the scanned bank takes the delayed read-then-clear and the other
    // bank takes engine writes; the engine write is applied last so it wins
    // should the two ever land on the same bank.
    always_comb begin
        b0_we    = 1'b0;
        b0_addr  = clr_addr_q;
        b0_wdata = TRANSPARENT;
        b1_we    = 1'b0;
        b1_addr  = clr_addr_q;
        b1_wdata = TRANSPARENT;
        if (!run) begin
            b0_we = clr_ok;
            b1_we = clr_ok;
        end else begin
            if (clr_p1) begin
                if (rd_bank_p1) begin
                    b1_we   = 1'b1;
                    b1_addr = rd_addr_p1;
                end else begin
                    b0_we   = 1'b1;
                    b0_addr = rd_addr_p1;
                end
            end
            if (eng_we) begin
                if (wsel_q) begin
                    b1_we    = 1'b1;
                    b1_addr  = sprite_pixel_col;
                    b1_wdata = sprite_pixel_data;
                end else begin
                    b0_we    = 1'b1;
                    b0_addr  = sprite_pixel_col;
                    b0_wdata = sprite_pixel_data;
                end
            end
        end
    end

    // Stage p1: registered RAM read of bank ~wsel plus the raster position
    // that goes with it. Blanking columns carry the transparent key.
    always_ff @(posedge clk) begin
        if (b0_we) bank0[b0_addr] <= b0_wdata;
        if (b1_we) bank1[b1_addr] <= b1_wdata;
        if (rd_en) begin
            rd_data_p1 <= wsel_q ? bank0[hcount] : bank1[hcount];
        end else begin
            rd_data_p1 <= TRANSPARENT;
        end
        rd_addr_p1 <= hcount;
        rd_bank_p1 <= ~wsel_q;
        hcount_p1  <= hcount;
        vcount_p1  <= vcount;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            clr_addr_q   <= 10'd0;
            wsel_q       <= 1'b0;
            ovr_q        <= 8'd0;
            start_q      <= 1'b0;
            vld_p1       <= 1'b0;
            clr_p1       <= 1'b0;
            pix_data_p2  <= 16'd0;
            pix_valid_p2 <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wsel_q     <= wsel_d;
            ovr_q      <= ovr_d;
            start_q    <= start_d;
            vld_p1     <= run && pix_ce;
            clr_p1     <= rd_en;
            // Stage p2: output register, updated once per pixel and held between.
            if (vld_p1) begin
                pix_data_p2  <= rd_data_p1;
                pix_valid_p2 <= (rd_data_p1 != TRANSPARENT) && (hcount_p1 < WIDTH_L)
                                && (vcount_p1 < V_VISIBLE);
            end
        end
    end

    assign sprite_start = start_q;
    assign pixel_data   = pix_data_p2;
    assign pixel_valid  = pix_valid_p2;
    assign init_done    = run;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_sprite_linebuf_scanout.sv
module tb_sprite_linebuf_scanout;

    localparam int          W = 640;
    localparam logic [15:0] T = 16'hF81F;
    localparam int          NL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [9:0]  hcount, vcount;
    logic [9:0]  sprite_pixel_col;
    logic [15:0] sprite_pixel_data;
    logic        wren_pixel_draw;
    logic        sprite_done;
    logic        sprite_start;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        init_done;
    logic [7:0]  overrun_cnt;

    always #5 clk = ~clk;

    sprite_linebuf_scanout #(.WIDTH(W), .TRANSPARENT(T)) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
        .sprite_pixel_col(sprite_pixel_col), .sprite_pixel_data(sprite_pixel_data),
        .wren_pixel_draw(wren_pixel_draw), .sprite_done(sprite_done),
        .sprite_start(sprite_start), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .init_done(init_done), .overrun_cnt(overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference: two line arrays, the displayed one is read and
    // cleared per pixel, the other collects engine writes; a swap exchanges roles.
    logic [15:0] m_bank [0:1][0:W-1];
    bit          m_run;
    int          m_init_cnt;
    int          m_wsel;
    int          m_ovr;
    bit          m_start;
    logic [15:0] m_pd;
    bit          m_pv;
    bit          p_has;
    logic [15:0] p_d;
    bit          p_v;

    // Per-line observations for the directed table.
    logic        obs_v [0:NL-1][0:W-1];
    logic [15:0] obs_d [0:NL-1][0:W-1];
    int          start_cnt [0:NL-1];
    int          start_ok  [0:NL-1];
    bit          hb_seen   [0:NL-1];
    int          cur_obs;
    bit          prev_ce;
    int          prev_h;

    logic [9:0]  wq_col [$];
    logic [15:0] wq_dat [$];
    bit          swap_wr_en;
    logic [9:0]  swap_col;
    logic [15:0] swap_dat;

    typedef struct {
        int          line;
        int          col;
        bit          exp_v;
        logic [15:0] exp_d;
        string       name;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int          h;
        logic [15:0] d;
        if (reset) begin
            m_run = 0; m_init_cnt = 0; m_wsel = 0; m_ovr = 0; m_start = 0;
            m_pd = 16'd0; m_pv = 0; p_has = 0;
            return;
        end
        if (!m_run) begin
            m_init_cnt++;
            m_start = 0;
            if (m_init_cnt == W) begin
                m_run = 1;
                for (int b = 0; b < 2; b++)
                    for (int c = 0; c < W; c++) m_bank[b][c] = T;
            end
            return;
        end
        if (p_has) begin
            m_pd = p_d;
            m_pv = p_v;
        end
        p_has   = 0;
        m_start = 0;
        if (wren_pixel_draw && int'(sprite_pixel_col) < W && sprite_pixel_data != T)
            m_bank[m_wsel][sprite_pixel_col] = sprite_pixel_data;
        if (pix_ce) begin
            h = int'(hcount);
            d = T;
            if (h < W) begin
                d = m_bank[1 - m_wsel][h];
                m_bank[1 - m_wsel][h] = T;
            end
            p_has = 1;
            p_d   = d;
            p_v   = (d != T) && (h < W) && (int'(vcount) < 480);
            if (h == 799) begin
                m_wsel = 1 - m_wsel;
                if (!sprite_done && m_ovr < 255) m_ovr++;
                m_start = 1;
            end
        end
    endtask

    task automatic step();
        bit ce_now;
        int h_now;
        ce_now = pix_ce;
        h_now  = int'(hcount);
        model_edge();
        @(posedge clk);
        #1;
        check("start", 32'(sprite_start), 32'(m_start));
        check("valid", 32'(pixel_valid), 32'(m_pv));
        check("init_done", 32'(init_done), 32'(m_run));
        check("overrun", 32'(overrun_cnt), 32'(m_ovr));
        if (m_pv) check("data", 32'(pixel_data), 32'(m_pd));
        if (cur_obs >= 0) begin
            if (prev_ce && prev_h < W) begin
                obs_v[cur_obs][prev_h] = pixel_valid;
                obs_d[cur_obs][prev_h] = pixel_data;
            end
            if (prev_ce && prev_h >= W && pixel_valid) hb_seen[cur_obs] = 1;
            if (sprite_start) begin
                start_cnt[cur_obs]++;
                if (ce_now && h_now == 799) start_ok[cur_obs]++;
            end
        end
        prev_ce = ce_now;
        prev_h  = h_now;
    endtask

    task automatic run_line(input int v, input bit done, input int obs_idx, input bit rnd);
        cur_obs     = obs_idx;
        vcount      = 10'(v);
        sprite_done = done;
        for (int h = 0; h < 800; h++) begin
            for (int ph = 0; ph < 2; ph++) begin
                pix_ce          = (ph == 0);
                hcount          = 10'(h);
                wren_pixel_draw = 1'b0;
                if (h == 799 && ph == 0 && swap_wr_en) begin
                    wren_pixel_draw   = 1'b1;
                    sprite_pixel_col  = swap_col;
                    sprite_pixel_data = swap_dat;
                    swap_wr_en        = 0;
                end else if (wq_col.size() > 0) begin
                    wren_pixel_draw   = 1'b1;
                    sprite_pixel_col  = wq_col.pop_front();
                    sprite_pixel_data = wq_dat.pop_front();
                end else if (rnd && $urandom_range(0, 7) == 0) begin
                    wren_pixel_draw   = 1'b1;
                    sprite_pixel_col  = 10'($urandom_range(0, 1023));
                    sprite_pixel_data = ($urandom_range(0, 3) == 0) ? T : 16'($urandom);
                end
                step();
            end
        end
        wren_pixel_draw = 1'b0;
        cur_obs = -1;
    endtask

    task automatic fast_swap(input int n, input bit done);
        sprite_done = done;
        for (int i = 0; i < n; i++) begin
            pix_ce = 1'b1; hcount = 10'd799; step();
            pix_ce = 1'b0; step();
        end
    endtask

    task automatic run_init(input string tag);
        int starts;
        starts = 0;
        for (int k = 1; k <= W; k++) begin
            pix_ce = k[0];
            step();
            if (sprite_start) starts++;
            if (k == W - 1) check({tag, "_init_639"}, 32'(init_done), 32'd0);
            if (k == W)     check({tag, "_init_640"}, 32'(init_done), 32'd1);
        end
        check({tag, "_no_start_in_init"}, 32'(starts), 32'd0);
        pix_ce = 1'b0;
    endtask

    initial begin
        tbl.push_back('{0, 0,   1'b0, 16'h0000, "init_l0_c0"});
        tbl.push_back('{0, 5,   1'b0, 16'h0000, "init_l0_c5"});
        tbl.push_back('{1, 639, 1'b0, 16'h0000, "init_l1_c639"});
        tbl.push_back('{2, 5,   1'b0, 16'h0000, "l10_c5_not_yet"});
        tbl.push_back('{3, 5,   1'b1, 16'h07E0, "l11_c5_green"});
        tbl.push_back('{3, 4,   1'b0, 16'h0000, "l11_c4"});
        tbl.push_back('{3, 6,   1'b0, 16'h0000, "l11_c6"});
        tbl.push_back('{3, 8,   1'b1, 16'hFFFF, "l11_c8_transp_dropped"});
        tbl.push_back('{3, 20,  1'b1, 16'h2222, "l11_c20_overwrite"});
        tbl.push_back('{3, 50,  1'b0, 16'h0000, "l11_c50_init_write_dropped"});
        tbl.push_back('{4, 5,   1'b0, 16'h0000, "l12_c5"});
        tbl.push_back('{4, 3,   1'b0, 16'h0000, "l12_c3_swap_write_not_early"});
        tbl.push_back('{5, 3,   1'b1, 16'h1234, "l13_c3_swap_write"});
        tbl.push_back('{5, 5,   1'b0, 16'h0000, "l13_c5_cleared"});
        tbl.push_back('{6, 9,   1'b0, 16'h0000, "v480_c9_blanked"});
        tbl.push_back('{8, 9,   1'b0, 16'h0000, "v482_c9_cleared"});

        for (int l = 0; l < NL; l++) begin
            start_cnt[l] = 0; start_ok[l] = 0; hb_seen[l] = 0;
        end
        cur_obs = -1; prev_ce = 0; prev_h = 0; swap_wr_en = 0;
        reset = 1'b1; pix_ce = 1'b0; hcount = 10'd0; vcount = 10'd0;
        sprite_pixel_col = 10'd0; sprite_pixel_data = 16'd0;
        wren_pixel_draw = 1'b0; sprite_done = 1'b1;

        repeat (3) step();
        check("rst_sprite_start", 32'(sprite_start), 32'd0);
        check("rst_pixel_data", 32'(pixel_data), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);

        // Engine writes during INIT must be ignored.
        reset = 1'b0;
        wren_pixel_draw = 1'b1; sprite_pixel_col = 10'd50; sprite_pixel_data = 16'h1234;
        run_init("first");
        wren_pixel_draw = 1'b0;

        run_line(0, 1, 0, 0);
        run_line(1, 1, 1, 0);
        wq_col = '{10'd5, 10'd700, 10'd8, 10'd8, 10'd20, 10'd20};
        wq_dat = '{16'h07E0, 16'h001F, 16'hFFFF, T, 16'h1111, 16'h2222};
        run_line(10, 1, 2, 0);
        run_line(11, 1, 3, 0);
        swap_wr_en = 1; swap_col = 10'd3; swap_dat = 16'h1234;
        run_line(12, 1, 4, 0);
        wq_col = '{10'd9};
        wq_dat = '{16'hABCD};
        run_line(13, 1, 5, 0);
        run_line(480, 1, 6, 0);
        run_line(481, 1, 7, 0);
        run_line(482, 1, 8, 0);

        foreach (tbl[i]) begin
            check({tbl[i].name, "_valid"}, 32'(obs_v[tbl[i].line][tbl[i].col]), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v)
                check({tbl[i].name, "_data"}, 32'(obs_d[tbl[i].line][tbl[i].col]), 32'(tbl[i].exp_d));
        end
        check("l11_c700_hidden", 32'(hb_seen[3]), 32'd0);
        for (int l = 0; l < 9; l++) begin
            check($sformatf("line%0d_start_count", l), 32'(start_cnt[l]), 32'd1);
            check($sformatf("line%0d_start_after_swap", l), 32'(start_ok[l]), 32'd1);
        end
        check("ovr_done_no_count", 32'(overrun_cnt), 32'd0);

        fast_swap(100, 0);
        check("ovr_100", 32'(overrun_cnt), 32'd100);
        fast_swap(155, 0);
        check("ovr_255", 32'(overrun_cnt), 32'd255);
        fast_swap(45, 0);
        check("ovr_sat", 32'(overrun_cnt), 32'd255);
        fast_swap(1, 1);
        check("ovr_done_hold", 32'(overrun_cnt), 32'd255);

        for (int i = 0; i < 6; i++)
            run_line($urandom_range(0, 524), 1'($urandom_range(0, 1)), -1, 1);

        // Reset in the middle of a visible line.
        vcount = 10'd100; sprite_done = 1'b1;
        for (int h = 0; h < 320; h++) begin
            pix_ce = 1'b1; hcount = 10'(h); step();
            pix_ce = 1'b0; step();
        end
        pix_ce = 1'b1; hcount = 10'd320; reset = 1'b1;
        step();
        check("midrst_sprite_start", 32'(sprite_start), 32'd0);
        check("midrst_pixel_data", 32'(pixel_data), 32'd0);
        check("midrst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        check("midrst_overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b0; hcount = 10'd0;
        run_init("midrst");
        run_line(5, 1, 9, 0);
        check("midrst_first_line_start", 32'(start_cnt[9]), 32'd1);
        check("midrst_first_line_start_after_swap", 32'(start_ok[9]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_linebuf_scanout.md
# sprite_linebuf_scanout

Consumer end of the sprite engine's pixel-write interface. It holds two 640×16-bit line buffers in ping-pong: the sprite engine writes line N+1 into one bank while the other bank is scanned out to the VGA compositor for line N. Each location is cleared to the transparent key right after it is read. At every line boundary the block swaps banks, issues `sprite_start`, and counts lines the engine failed to finish in time.

## Interface
Parameters:
- `WIDTH`, 640, visible columns per line (buffer depth).
- `TRANSPARENT`, 16'hF81F, RGB565 key meaning "no sprite pixel".

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `pix_ce`  in  1  pixel clock enable; one cycle in every two.
- `hcount`  in  10  current pixel column, 0–799.
- `vcount`  in  10  current line, 0–524.
- `sprite_pixel_col`  in  10  write column from the sprite engine.
- `sprite_pixel_data`  in  16  RGB565 write data.
- `wren_pixel_draw`  in  1  write strobe.
- `sprite_done`  in  1  engine finished the current line, level.
- `sprite_start`  out  1  one-cycle pulse telling the engine to render the next line.
- `pixel_data`  out  16  RGB565 sprite pixel for the compositor.
- `pixel_valid`  out  1  `pixel_data` is opaque and should be shown over the background.
- `init_done`  out  1  the initial buffer clear is complete.
- `overrun_cnt`  out  8  saturating count of late lines.

## Operation
- FSM states:
  - INIT: after reset, a 10-bit `clr_addr` counts 0..WIDTH-1, one per clk (not gated by `pix_ce`), writing `TRANSPARENT` to the same address in both banks. The cycle after `clr_addr == WIDTH-1`, go to RUN and set `init_done` to 1.
  - RUN: normal operation. Leaves RUN only on reset.
- Bank select `wsel`, 1 bit, reset 0. The engine writes bank `wsel`; scanout reads bank `~wsel`.
- Engine write, RUN only:
  - If `wren_pixel_draw` is high, `sprite_pixel_col < WIDTH`, and `sprite_pixel_data != TRANSPARENT`, write the data into bank `wsel` at `sprite_pixel_col`. Otherwise drop the write.
  - A later write to the same column overwrites the earlier one.
  - During INIT all engine writes are dropped.
- Scanout, RUN only: on each `pix_ce` with `hcount < WIDTH`, read bank `~wsel` at `hcount`. On the following cycle, write `TRANSPARENT` to that same address (read-then-clear).
  - This read/clear runs on every line, including vblank, so both banks stay clean.
- Output gating: `pixel_valid = (data != TRANSPARENT) && (hcount_d < WIDTH) && (vcount_d < 480)`, using `hcount`/`vcount` delayed to match the read pipeline.
- Swap: on `pix_ce` with `hcount == 799` in RUN:
  - Toggle `wsel`.
  - If `sprite_done == 0` at that edge, increment `overrun_cnt`, saturating at 255. The stale partial line is still swapped in and shown.
- `sprite_start` pulses for one cycle, the cycle after each swap. It is never asserted in INIT.

## Timing
- Reset values: `wsel = 0`, FSM = INIT, `clr_addr = 0`. All outputs 0: `sprite_start`, `pixel_data`, `pixel_valid`, `init_done`, `overrun_cnt`.
- Reset mid-line or mid-INIT: restart INIT from address 0. Buffer contents before reset do not matter.
- INIT takes exactly WIDTH = 640 cycles; `init_done` rises on cycle 641 after reset deasserts.
- Read latency: for the `pix_ce` edge presenting `hcount = h`, the column-h values of `pixel_data`/`pixel_valid` appear 2 clk later (registered RAM read plus output register). They hold until the next update.
- Same-cycle engine write and swap: the write goes to the bank selected by `wsel` before the swap edge.
- Read/clear and engine write never target the same bank, so no port conflict. Each bank needs one write port (engine or clear, muxed by `wsel`) and one read port.
- Engine budget: 800 × 2 = 1600 clk per line, from `sprite_start` to the next swap.
- Columns ≥ WIDTH are never written or read. `hcount` 640–799 only advances toward the swap.

## Test plan
- Reset, then 640 idle cycles: `init_done` rises on cycle 641. Every read in the next two lines gives `pixel_valid = 0`.
- In RUN, write col 5 = 16'h07E0 during line 10, then let it swap: during line 11, `hcount = 5` gives `pixel_data = 07E0`, `pixel_valid = 1` at +2 clk. Columns 4 and 6 are invalid. On line 13, col 5 is invalid again (it was cleared).
- Write col 700 = 16'h001F, and col 8 = `TRANSPARENT` on top of an earlier 16'hFFFF: col 700 is never visible. Col 8 shows FFFF, because the transparent write was dropped.
- Hold `sprite_done = 0` across 300 swaps: `overrun_cnt` reaches 255 and stays there. With `sprite_done = 1` at swap, the count does not change.
- Write col 3 on the same cycle as a swap: the pixel appears on the next displayed line. `sprite_start` pulses exactly 1 cycle, the cycle after the swap.
- Assert reset at `hcount = 320` of a line: all outputs 0 on the next cycle, INIT reruns for 640 cycles, and there is no `sprite_start` until the first swap after `init_done`.
